// File: rtl/pipeline_tag_pkg.sv
// Shared types and default widths for the pipeline tag tracker.
package pipeline_tag_pkg;

  localparam int ID_W_DEFAULT   = 7;
  localparam int SCNT_W_DEFAULT = 3;

  // One pipeline slot: whether it holds a live instruction, and that instruction's tag.
  typedef struct packed {
    logic                    valid;
    logic [ID_W_DEFAULT-1:0] tag;
  } stage_tag_t;

endpackage

// File: rtl/pipeline_tag_tracker_stage.sv
// Generic pipeline slot register used for the EX, MEM and WB stages.
// A bubble kills the slot but leaves the stale tag in place; only valid matters then.
module tag_stage_reg
  import pipeline_tag_pkg::*;
#(
  parameter type stage_t = stage_tag_t
) (
  input  logic   clk,
  input  logic   rst,
  input  logic   load,
  input  logic   bubble,
  input  stage_t d,
  output stage_t q
);

  // Reset clears the slot, a bubble invalidates it, otherwise it captures the upstream slot.
  always_ff @(posedge clk) begin
    if (rst) begin
      q <= '0;
    end else if (bubble) begin
      q.valid <= 1'b0;
    end else if (load) begin
      q <= d;
    end
  end

endmodule

// File: rtl/pipeline_tag_tracker.sv
// Tracks sequence tags through a five-stage IF/ID/EX/MEM/WB pipeline with stall,
// branch flush, per-stage stall counters and a retirement counter.
module pipeline_tag_tracker
  import pipeline_tag_pkg::*;
#(
  parameter int ID_W   = ID_W_DEFAULT,
  parameter int SCNT_W = SCNT_W_DEFAULT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stall,
  input  logic              flush,
  output logic              if_valid,
  output logic              id_valid,
  output logic              ex_valid,
  output logic              mem_valid,
  output logic              wb_valid,
  output logic [ID_W-1:0]   if_tag,
  output logic [ID_W-1:0]   id_tag,
  output logic [ID_W-1:0]   ex_tag,
  output logic [ID_W-1:0]   mem_tag,
  output logic [ID_W-1:0]   wb_tag,
  output logic [SCNT_W-1:0] if_stall_cnt,
  output logic [SCNT_W-1:0] id_stall_cnt,
  output logic              squash_valid,
  output logic [ID_W-1:0]   squash_tag,
  output logic [31:0]       retire_cnt
);

  typedef struct packed {
    logic            valid;
    logic [ID_W-1:0] tag;
  } stage_t;

  localparam logic [SCNT_W-1:0] SCNT_MAX = '1;

  logic [ID_W-1:0] fetch_tag;
  stage_t          id_q;
  stage_t          ex_q;
  stage_t          mem_q;
  stage_t          wb_q;

  // IF always holds a live instruction except while reset is being applied.
  assign if_valid = ~rst;
  assign if_tag   = fetch_tag;

  // Fetch tag advances every unstalled cycle; a flushed tag is consumed, not reused.
  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_tag <= '0;
    end else if (!stall) begin
      fetch_tag <= fetch_tag + 1'b1;
    end
  end

  // ID captures the IF slot unless stalled; a flush turns the captured slot into a bubble.
  always_ff @(posedge clk) begin
    if (rst) begin
      id_q <= '0;
    end else if (!stall) begin
      id_q.valid <= ~flush;
      id_q.tag   <= fetch_tag;
    end
  end

  // A flush that is not overridden by a stall reports the killed IF tag for one cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      squash_valid <= 1'b0;
      squash_tag   <= '0;
    end else if (flush && !stall) begin
      squash_valid <= 1'b1;
      squash_tag   <= fetch_tag;
    end else begin
      squash_valid <= 1'b0;
    end
  end

  // Saturating stall counters; ID only counts while it actually holds an instruction.
  always_ff @(posedge clk) begin
    if (rst || !stall) begin
      if_stall_cnt <= '0;
      id_stall_cnt <= '0;
    end else begin
      if (if_stall_cnt != SCNT_MAX) begin
        if_stall_cnt <= if_stall_cnt + 1'b1;
      end
      if (!id_q.valid) begin
        id_stall_cnt <= '0;
      end else if (id_stall_cnt != SCNT_MAX) begin
        id_stall_cnt <= id_stall_cnt + 1'b1;
      end
    end
  end

  // Count every live instruction as it moves from MEM into WB.
  always_ff @(posedge clk) begin
    if (rst) begin
      retire_cnt <= '0;
    end else if (mem_q.valid) begin
      retire_cnt <= retire_cnt + 32'd1;
    end
  end

  tag_stage_reg #(.stage_t(stage_t)) u_ex (
    .clk    (clk),
    .rst    (rst),
    .load   (1'b1),
    .bubble (stall),
    .d      (id_q),
    .q      (ex_q)
  );

  tag_stage_reg #(.stage_t(stage_t)) u_mem (
    .clk    (clk),
    .rst    (rst),
    .load   (1'b1),
    .bubble (1'b0),
    .d      (ex_q),
    .q      (mem_q)
  );

  tag_stage_reg #(.stage_t(stage_t)) u_wb (
    .clk    (clk),
    .rst    (rst),
    .load   (1'b1),
    .bubble (1'b0),
    .d      (mem_q),
    .q      (wb_q)
  );

  assign id_valid  = id_q.valid;
  assign id_tag    = id_q.tag;
  assign ex_valid  = ex_q.valid;
  assign ex_tag    = ex_q.tag;
  assign mem_valid = mem_q.valid;
  assign mem_tag   = mem_q.tag;
  assign wb_valid  = wb_q.valid;
  assign wb_tag    = wb_q.tag;

endmodule

// File: tb/tb_pipeline_tag_tracker.sv
// Directed testbench for pipeline_tag_tracker. Cycle k is the interval after the k-th
// clock edge following the reset edge; outputs are sampled 1 time unit after each edge.
module tb_pipeline_tag_tracker;

  localparam int ID_W   = 7;
  localparam int SCNT_W = 3;

  logic              clk = 1'b0;
  logic              rst;
  logic              stall;
  logic              flush;
  logic              if_valid, id_valid, ex_valid, mem_valid, wb_valid;
  logic [ID_W-1:0]   if_tag, id_tag, ex_tag, mem_tag, wb_tag;
  logic [SCNT_W-1:0] if_stall_cnt, id_stall_cnt;
  logic              squash_valid;
  logic [ID_W-1:0]   squash_tag;
  logic [31:0]       retire_cnt;

  int tests = 0;
  int fails = 0;

  pipeline_tag_tracker #(.ID_W(ID_W), .SCNT_W(SCNT_W)) dut (
    .clk          (clk),
    .rst          (rst),
    .stall        (stall),
    .flush        (flush),
    .if_valid     (if_valid),
    .id_valid     (id_valid),
    .ex_valid     (ex_valid),
    .mem_valid    (mem_valid),
    .wb_valid     (wb_valid),
    .if_tag       (if_tag),
    .id_tag       (id_tag),
    .ex_tag       (ex_tag),
    .mem_tag      (mem_tag),
    .wb_tag       (wb_tag),
    .if_stall_cnt (if_stall_cnt),
    .id_stall_cnt (id_stall_cnt),
    .squash_valid (squash_valid),
    .squash_tag   (squash_tag),
    .retire_cnt   (retire_cnt)
  );

  always #5 clk = ~clk;

  // Drive one cycle of control inputs and sample just after the edge.
  task automatic tick(input logic s, input logic f);
    stall = s;
    flush = f;
    @(posedge clk);
    #1;
  endtask

  // One reset edge, then release; leaves the bench in cycle 0.
  task automatic do_reset();
    rst   = 1'b1;
    stall = 1'b0;
    flush = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
  endtask

  task automatic test_reset();
    rst   = 1'b1;
    stall = 1'b1;
    flush = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    tests++; if (if_valid !== 1'b0) begin fails++; $display("[TB] FAIL reset_if_valid: got %b want 0", if_valid); end
    tests++; if ({id_valid, ex_valid, mem_valid, wb_valid} !== 4'b0000) begin fails++; $display("[TB] FAIL reset_valids: got %b want 0000", {id_valid, ex_valid, mem_valid, wb_valid}); end
    tests++; if (squash_valid !== 1'b0) begin fails++; $display("[TB] FAIL reset_squash: got %b want 0", squash_valid); end
    tests++; if (retire_cnt !== 32'd0) begin fails++; $display("[TB] FAIL reset_retire: got %0d want 0", retire_cnt); end
    tests++; if ({if_stall_cnt, id_stall_cnt} !== 6'd0) begin fails++; $display("[TB] FAIL reset_stall_cnts: got %0d/%0d want 0/0", if_stall_cnt, id_stall_cnt); end
    tests++; if ({if_tag, id_tag, ex_tag, mem_tag, wb_tag, squash_tag} !== '0) begin fails++; $display("[TB] FAIL reset_tags: got %0d %0d %0d %0d %0d %0d want all 0", if_tag, id_tag, ex_tag, mem_tag, wb_tag, squash_tag); end
    rst   = 1'b0;
    stall = 1'b0;
    flush = 1'b0;
    #1;
    tests++; if (if_valid !== 1'b1 || if_tag !== 7'd0) begin fails++; $display("[TB] FAIL release_if: got v=%b tag=%0d want v=1 tag=0", if_valid, if_tag); end
    tick(1'b0, 1'b0);
    tests++; if (id_valid !== 1'b1 || id_tag !== 7'd0 || if_tag !== 7'd1) begin fails++; $display("[TB] FAIL first_advance: got id v=%b tag=%0d if=%0d want 1/0/1", id_valid, id_tag, if_tag); end
  endtask

  task automatic test_basic_flow();
    do_reset();
    for (int k = 0; k < 10; k++) begin
      tests++; if (if_tag !== 7'(k)) begin fails++; $display("[TB] FAIL basic_if_tag c%0d: got %0d want %0d", k, if_tag, k); end
      tests++; if (wb_valid !== (k >= 4)) begin fails++; $display("[TB] FAIL basic_wb_valid c%0d: got %b want %b", k, wb_valid, (k >= 4)); end
      if (k >= 4) begin
        tests++; if (wb_tag !== 7'(k - 4)) begin fails++; $display("[TB] FAIL basic_wb_tag c%0d: got %0d want %0d", k, wb_tag, k - 4); end
      end
      tests++; if (retire_cnt !== 32'((k >= 4) ? k - 3 : 0)) begin fails++; $display("[TB] FAIL basic_retire c%0d: got %0d want %0d", k, retire_cnt, (k >= 4) ? k - 3 : 0); end
      tests++; if (squash_valid !== 1'b0) begin fails++; $display("[TB] FAIL basic_squash c%0d: got %b want 0", k, squash_valid); end
      tick(1'b0, 1'b0);
    end
  endtask

  task automatic test_stall();
    do_reset();
    repeat (5) tick(1'b0, 1'b0);
    tests++; if (id_tag !== 7'd4 || ex_tag !== 7'd3) begin fails++; $display("[TB] FAIL stall_setup: got id=%0d ex=%0d want 4/3", id_tag, ex_tag); end
    for (int j = 1; j <= 3; j++) begin
      tick(1'b1, 1'b0);
      tests++; if (id_tag !== 7'd4 || id_valid !== 1'b1) begin fails++; $display("[TB] FAIL stall_id_hold s%0d: got v=%b tag=%0d want 1/4", j, id_valid, id_tag); end
      tests++; if (if_tag !== 7'd5) begin fails++; $display("[TB] FAIL stall_if_hold s%0d: got %0d want 5", j, if_tag); end
      tests++; if (id_stall_cnt !== 3'(j) || if_stall_cnt !== 3'(j)) begin fails++; $display("[TB] FAIL stall_cnt s%0d: got if=%0d id=%0d want %0d", j, if_stall_cnt, id_stall_cnt, j); end
      tests++; if (ex_valid !== 1'b0) begin fails++; $display("[TB] FAIL stall_bubble s%0d: got %b want 0", j, ex_valid); end
    end
    tick(1'b0, 1'b0);
    tests++; if (id_stall_cnt !== 3'd0 || if_stall_cnt !== 3'd0) begin fails++; $display("[TB] FAIL stall_cnt_clear: got if=%0d id=%0d want 0/0", if_stall_cnt, id_stall_cnt); end
    tests++; if (ex_valid !== 1'b1 || ex_tag !== 7'd4 || id_tag !== 7'd5) begin fails++; $display("[TB] FAIL stall_resume: got ex v=%b tag=%0d id=%0d want 1/4/5", ex_valid, ex_tag, id_tag); end
    tick(1'b0, 1'b0);
    tests++; if (wb_valid !== 1'b0 || mem_tag !== 7'd4) begin fails++; $display("[TB] FAIL stall_wb_bubble: got wb_v=%b mem=%0d want 0/4", wb_valid, mem_tag); end
    tick(1'b0, 1'b0);
    tests++; if (wb_valid !== 1'b1 || wb_tag !== 7'd4) begin fails++; $display("[TB] FAIL stall_late_retire: got v=%b tag=%0d want 1/4", wb_valid, wb_tag); end
    tests++; if (retire_cnt !== 32'd5) begin fails++; $display("[TB] FAIL stall_retire_cnt: got %0d want 5", retire_cnt); end
  endtask

  task automatic test_stall_saturate();
    do_reset();
    tick(1'b1, 1'b0);
    tests++; if (id_valid !== 1'b0 || id_stall_cnt !== 3'd0 || if_stall_cnt !== 3'd1) begin fails++; $display("[TB] FAIL stall_empty_id: got id_v=%b id_cnt=%0d if_cnt=%0d want 0/0/1", id_valid, id_stall_cnt, if_stall_cnt); end
    tick(1'b0, 1'b0);
    tick(1'b0, 1'b0);
    repeat (9) tick(1'b1, 1'b0);
    tests++; if (id_stall_cnt !== 3'd7 || if_stall_cnt !== 3'd7) begin fails++; $display("[TB] FAIL stall_saturate: got if=%0d id=%0d want 7/7", if_stall_cnt, id_stall_cnt); end
    tick(1'b0, 1'b0);
    tests++; if (id_stall_cnt !== 3'd0) begin fails++; $display("[TB] FAIL stall_sat_clear: got %0d want 0", id_stall_cnt); end
  endtask

  task automatic test_flush();
    do_reset();
    repeat (7) tick(1'b0, 1'b0);
    tests++; if (if_tag !== 7'd7) begin fails++; $display("[TB] FAIL flush_setup: got %0d want 7", if_tag); end
    tick(1'b0, 1'b1);
    tests++; if (squash_valid !== 1'b1 || squash_tag !== 7'd7) begin fails++; $display("[TB] FAIL flush_squash: got v=%b tag=%0d want 1/7", squash_valid, squash_tag); end
    tests++; if (id_valid !== 1'b0 || if_tag !== 7'd8) begin fails++; $display("[TB] FAIL flush_kill: got id_v=%b if=%0d want 0/8", id_valid, if_tag); end
    for (int c = 9; c < 14; c++) begin
      tick(1'b0, 1'b0);
      tests++; if (squash_valid !== 1'b0) begin fails++; $display("[TB] FAIL flush_pulse_end c%0d: got %b want 0", c, squash_valid); end
      tests++; if (wb_valid !== (c != 11)) begin fails++; $display("[TB] FAIL flush_wb_valid c%0d: got %b want %b", c, wb_valid, (c != 11)); end
      if (c != 11) begin
        tests++; if (wb_tag !== 7'(c - 4)) begin fails++; $display("[TB] FAIL flush_wb_tag c%0d: got %0d want %0d", c, wb_tag, c - 4); end
      end
    end
  endtask

  task automatic test_flush_stall();
    do_reset();
    repeat (5) tick(1'b0, 1'b0);
    tick(1'b1, 1'b1);
    tests++; if (squash_valid !== 1'b0) begin fails++; $display("[TB] FAIL fs_no_squash: got %b want 0", squash_valid); end
    tests++; if (if_tag !== 7'd5 || id_tag !== 7'd4 || id_valid !== 1'b1) begin fails++; $display("[TB] FAIL fs_hold: got if=%0d id v=%b tag=%0d want 5/1/4", if_tag, id_valid, id_tag); end
    tests++; if (ex_valid !== 1'b0) begin fails++; $display("[TB] FAIL fs_bubble: got %b want 0", ex_valid); end
    tick(1'b0, 1'b0);
    tests++; if (ex_valid !== 1'b1 || ex_tag !== 7'd4 || mem_valid !== 1'b0 || squash_valid !== 1'b0) begin fails++; $display("[TB] FAIL fs_single_bubble: got ex v=%b tag=%0d mem_v=%b sq=%b want 1/4/0/0", ex_valid, ex_tag, mem_valid, squash_valid); end
  endtask

  task automatic test_wrap();
    do_reset();
    for (int k = 0; k < 132; k++) begin
      tests++; if (if_tag !== 7'(k)) begin fails++; $display("[TB] FAIL wrap_if_tag c%0d: got %0d want %0d", k, if_tag, k % 128); end
      if (k >= 4) begin
        tests++; if (wb_valid !== 1'b1 || wb_tag !== 7'(k - 4)) begin fails++; $display("[TB] FAIL wrap_wb c%0d: got v=%b tag=%0d want 1/%0d", k, wb_valid, wb_tag, (k - 4) % 128); end
      end
      tick(1'b0, 1'b0);
    end
    tests++; if (retire_cnt !== 32'd129) begin fails++; $display("[TB] FAIL wrap_retire: got %0d want 129", retire_cnt); end
  endtask

  task automatic test_reset_midflight();
    do_reset();
    repeat (6) tick(1'b0, 1'b0);
    tests++; if ({id_valid, ex_valid, mem_valid, wb_valid} !== 4'b1111) begin fails++; $display("[TB] FAIL mid_setup: got %b want 1111", {id_valid, ex_valid, mem_valid, wb_valid}); end
    rst   = 1'b1;
    stall = 1'b1;
    flush = 1'b1;
    @(posedge clk);
    #1;
    tests++; if ({if_valid, id_valid, ex_valid, mem_valid, wb_valid} !== 5'b00000) begin fails++; $display("[TB] FAIL mid_valids: got %b want 00000", {if_valid, id_valid, ex_valid, mem_valid, wb_valid}); end
    tests++; if (retire_cnt !== 32'd0 || squash_valid !== 1'b0) begin fails++; $display("[TB] FAIL mid_retire_squash: got %0d/%b want 0/0", retire_cnt, squash_valid); end
    rst   = 1'b0;
    stall = 1'b0;
    flush = 1'b0;
    #1;
    tests++; if (if_valid !== 1'b1 || if_tag !== 7'd0) begin fails++; $display("[TB] FAIL mid_restart_if: got v=%b tag=%0d want 1/0", if_valid, if_tag); end
    tick(1'b0, 1'b0);
    tests++; if (id_valid !== 1'b1 || id_tag !== 7'd0 || squash_valid !== 1'b0) begin fails++; $display("[TB] FAIL mid_restart_id: got v=%b tag=%0d sq=%b want 1/0/0", id_valid, id_tag, squash_valid); end
  endtask

  initial begin
    rst   = 1'b1;
    stall = 1'b0;
    flush = 1'b0;
    test_reset();
    test_basic_flow();
    test_stall();
    test_stall_saturate();
    test_flush();
    test_flush_stall();
    test_wrap();
    test_reset_midflight();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation did not complete in time");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
